pad_scan_counter: RTL

PAD_SCAN_COUNTER -- requirements
Module: pad_scan_counter

---
 rtl/pad_pkg.sv | 40 ++++
 rtl/pad_scan_counter_if.sv | 44 ++++
 rtl/wrap_counter.sv | 30 +++
 rtl/pad_scan_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared types and width helpers for the padded feature-map scan counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pad_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Bits needed to index n values; never narrower than one bit so that
  // degenerate sizes (CH=1, 1-pixel maps) still give legal vectors.
  function automatic int width_of(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Channel index width.
  function automatic int cw_of(input int ch);
    return width_of(ch);
  endfunction

  // Padded column index width.
  function automatic int xw_of(input int img_w, input int pad);
    return width_of(img_w + 2 * pad);
  endfunction

  // Padded row index width.
  function automatic int yw_of(input int img_h, input int pad);
    return width_of(img_h + 2 * pad);
  endfunction

  // Linear source-pixel address width.
  function automatic int aw_of(input int img_w, input int img_h);
    return width_of(img_w * img_h);
  endfunction

endpackage

// File: rtl/pad_scan_counter_if.sv
// Position stream from the scan counter to the downstream consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer drives out_ready; a position is held until accepted.
interface pad_scan_counter_if #(
  parameter int CW = 1,
  parameter int XW = 1,
  parameter int YW = 1,
  parameter int AW = 1
);

  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] chan;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          pad_flag;
  logic [AW-1:0] src_addr;
  logic          last;

  // Producer side: the scan counter.
  modport master (
    output out_valid,
    output chan,
    output col,
    output row,
    output pad_flag,
    output src_addr,
    output last,
    input  out_ready
  );

  // Consumer side: whatever reads the pixel stream.
  modport slave (
    input  out_valid,
    input  chan,
    input  col,
    input  row,
    input  pad_flag,
    input  src_addr,
    input  last,
    output out_ready
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up counter with synchronous clear and terminal-count flag.
// Latency: value updates on the clock edge after inc/clr.
// Backpressure: none; holds whenever inc and clr are both low.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         at_max
);

  logic [W-1:0] r_value;

  // Count up on inc, wrapping to zero after MAX; reset/clr win over inc.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= at_max ? '0 : r_value + W'(1);
    end
  end

  assign at_max = (r_value == W'(MAX));
  assign value  = r_value;

endmodule

// File: rtl/pad_scan_counter.sv
// Walks a zero-padded feature map channel-fastest, then column, then row.
// Latency: first position valid the cycle after an accepted start.
// Backpressure: position held stable while out_ready is low; en=0 freezes all.
module pad_scan_counter
  import pad_pkg::*;
#(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int CH    = 3,
  parameter int PAD   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start,
  output logic busy,
  output logic frame_done,
  pad_scan_counter_if.master o_scan
);

  localparam int CW   = cw_of(CH);
  localparam int XW   = xw_of(IMG_W, PAD);
  localparam int YW   = yw_of(IMG_H, PAD);
  localparam int AW   = aw_of(IMG_W, IMG_H);
  localparam int COLS = IMG_W + 2 * PAD;
  localparam int ROWS = IMG_H + 2 * PAD;

  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic          w_out_valid;
  logic          w_frame_done;
  logic          w_clr;
  logic          w_xfer;
  logic          w_last;
  logic          w_pad;
  logic          w_chan_max;
  logic          w_col_max;
  logic          w_row_max;
  logic [CW-1:0] w_chan;
  logic [XW-1:0] w_col;
  logic [YW-1:0] w_row;
  logic [AW-1:0] w_src_addr;

  // A handshake only happens on a valid cycle, so en=0 also blocks transfers.
  assign w_xfer = w_out_valid & o_scan.out_ready;

  // Final position of the frame; only meaningful while scanning.
  assign w_last = w_chan_max & w_col_max & w_row_max & (r_state == ST_SCAN);

  // State register; en=0 freezes the controller without clearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; out_valid depends only on state and en.
  always_comb begin
    w_state_nxt  = r_state;
    w_out_valid  = 1'b0;
    w_frame_done = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && en) begin
          w_state_nxt = ST_SCAN;
          w_clr       = 1'b1;
        end
      end
      ST_SCAN: begin
        w_out_valid = en;
        if (w_xfer && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_frame_done = en;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Channel is the fastest-moving index.
  wrap_counter #(.MAX(CH - 1), .W(CW)) u_chan_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_xfer),
    .clr    (w_clr),
    .value  (w_chan),
    .at_max (w_chan_max)
  );

  // Column advances when the channel wraps.
  wrap_counter #(.MAX(COLS - 1), .W(XW)) u_col_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_xfer & w_chan_max),
    .clr    (w_clr),
    .value  (w_col),
    .at_max (w_col_max)
  );

  // Row advances when both channel and column wrap; it wraps on the last
  // transfer so all three counters are back at zero in DONE.
  wrap_counter #(.MAX(ROWS - 1), .W(YW)) u_row_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_xfer & w_chan_max & w_col_max),
    .clr    (w_clr),
    .value  (w_row),
    .at_max (w_row_max)
  );

  // Border detect; with no padding there is no border to flag.
  generate
    if (PAD == 0) begin : g_no_pad
      assign w_pad = 1'b0;
    end else begin : g_pad
      assign w_pad = (32'(w_row) <  32'(PAD))
                  || (32'(w_row) >= 32'(IMG_H + PAD))
                  || (32'(w_col) <  32'(PAD))
                  || (32'(w_col) >= 32'(IMG_W + PAD));
    end
  endgenerate

  // Interior pixels map back to the unpadded image; the product is formed in
  // 32 bits and then narrowed, so border positions (forced to 0) may wrap freely.
  assign w_src_addr = w_pad ? '0
                    : AW'((32'(w_row) - 32'(PAD)) * 32'(IMG_W)
                          + (32'(w_col) - 32'(PAD)));

  assign o_scan.out_valid = w_out_valid;
  assign o_scan.chan      = w_chan;
  assign o_scan.col       = w_col;
  assign o_scan.row       = w_row;
  assign o_scan.pad_flag  = w_pad;
  assign o_scan.src_addr  = w_src_addr;
  assign o_scan.last      = w_last;
  assign busy             = (r_state != ST_IDLE);
  assign frame_done       = w_frame_done;

endmodule
